// File: rtl/uart_cmd_initiator.sv
// ----------------------------------------------------------------------------
// uart_cmd_initiator
//   Host-side initiator for the UART-AXI4 bridge frame protocol. Turns one
//   single-word read/write request into a command frame on a byte stream,
//   then parses the bridge's response frame and returns data and status.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_rw               1 = read, 0 = write
//   req_addr, req_wdata  32-bit AXI byte address / write data
//   tx_data/tx_valid     byte stream toward the UART transmitter
//   tx_ready             transmitter accepts the current byte
//   rx_data/rx_valid     byte strobe from the UART receiver (no backpressure)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and errors)
//   rsp_status           STATUS byte returned by the bridge (0 on local error)
//   rsp_code             0 OK, 1 remote error, 2 CRC/format error, 3 timeout
//   busy                 high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module uart_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_CMD        = 8'hA5,
  parameter logic [7:0]  SOF_RSP        = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  rsp_status,
  output logic [1:0]  rsp_code,
  output logic        busy
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] TX_SOF    = 4'd1;
  localparam logic [3:0] TX_CMD    = 4'd2;
  localparam logic [3:0] TX_ADDR   = 4'd3;
  localparam logic [3:0] TX_DATA   = 4'd4;
  localparam logic [3:0] TX_CRC    = 4'd5;
  localparam logic [3:0] RX_SOF    = 4'd6;
  localparam logic [3:0] RX_STATUS = 4'd7;
  localparam logic [3:0] RX_CMD    = 4'd8;
  localparam logic [3:0] RX_DATA   = 4'd9;
  localparam logic [3:0] RX_CRC    = 4'd10;
  localparam logic [3:0] RESP      = 4'd11;

  // CRC8, polynomial 0x07, MSB-first, one byte at a time.
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  logic [3:0]    state_q;
  logic          rw_q;
  logic [63:0]   payload_q;   // {wdata, addr}, shifted out LSB byte first
  logic [2:0]    byte_cnt;    // index of the address/data byte in flight
  logic [7:0]    crc_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    status_q;
  logic [31:0]   rdata_q;
  logic          cmd_err_q;

  logic [7:0] cmd_byte;
  logic [7:0] crc_tx_next;
  logic [7:0] crc_rx_next;
  logic       last_payload;
  logic       in_rx;

  assign cmd_byte     = {rw_q, 1'b0, 2'b10, 4'h0};
  assign crc_tx_next  = crc8(crc_q, tx_data);
  assign crc_rx_next  = crc8(crc_q, rx_data);
  assign last_payload = rw_q ? (byte_cnt == 3'd3) : (byte_cnt == 3'd7);
  assign in_rx        = (state_q >= RX_SOF) && (state_q <= RX_CRC);

  // NOTE: req_ready and busy are decoded from the state register rather than
  // registered separately, so an asserted rst_n reaches them with no clock.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // NOTE: all state uses non-blocking assignments inside one clocked block;
  // blocking assignments here would make results depend on evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      payload_q  <= '0;
      byte_cnt   <= '0;
      crc_q      <= '0;
      timer_q    <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      cmd_err_q  <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
      rsp_code   <= 2'd0;
    end else begin
      // Inter-byte timeout: any received byte restarts the window.
      if (in_rx) begin
        if (rx_valid) begin
          timer_q <= '0;
        end else if (timer_q == TIMER_LAST) begin
          state_q    <= RESP;
          rsp_valid  <= 1'b1;
          rsp_code   <= 2'd3;
          rsp_status <= '0;
          rsp_rdata  <= '0;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rw_q      <= req_rw;
            payload_q <= {req_wdata, req_addr};
            cmd_err_q <= 1'b0;
            crc_q     <= '0;
            tx_data   <= SOF_CMD;
            tx_valid  <= 1'b1;
            state_q   <= TX_SOF;
          end
        end
        TX_SOF: begin
          if (tx_ready) begin
            tx_data <= cmd_byte;
            state_q <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (tx_ready) begin
            crc_q     <= crc_tx_next;
            tx_data   <= payload_q[7:0];
            payload_q <= payload_q >> 8;
            byte_cnt  <= '0;
            state_q   <= TX_ADDR;
          end
        end
        TX_ADDR, TX_DATA: begin
          if (tx_ready) begin
            crc_q <= crc_tx_next;
            if (last_payload) begin
              // The CRC byte already includes the byte leaving right now.
              tx_data <= crc_tx_next;
              state_q <= TX_CRC;
            end else begin
              tx_data   <= payload_q[7:0];
              payload_q <= payload_q >> 8;
              byte_cnt  <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd3) state_q <= TX_DATA;
            end
          end
        end
        TX_CRC: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            crc_q    <= '0;
            timer_q  <= '0;
            state_q  <= RX_SOF;
          end
        end
        RX_SOF: begin
          if (rx_valid && (rx_data == SOF_RSP)) begin
            crc_q   <= '0;
            state_q <= RX_STATUS;
          end
        end
        RX_STATUS: begin
          if (rx_valid) begin
            status_q <= rx_data;
            crc_q    <= crc_rx_next;
            state_q  <= RX_CMD;
          end
        end
        RX_CMD: begin
          if (rx_valid) begin
            cmd_err_q <= (rx_data != cmd_byte);
            crc_q     <= crc_rx_next;
            byte_cnt  <= '0;
            // Data bytes follow only for a read the bridge completed cleanly.
            state_q   <= (rw_q && (status_q == 8'h00)) ? RX_DATA : RX_CRC;
          end
        end
        RX_DATA: begin
          if (rx_valid) begin
            rdata_q  <= {rx_data, rdata_q[31:8]};
            crc_q    <= crc_rx_next;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd3) state_q <= RX_CRC;
          end
        end
        RX_CRC: begin
          if (rx_valid) begin
            rsp_valid <= 1'b1;
            state_q   <= RESP;
            if ((rx_data != crc_q) || cmd_err_q) begin
              rsp_code   <= 2'd2;
              rsp_status <= '0;
              rsp_rdata  <= '0;
            end else if (status_q != 8'h00) begin
              rsp_code   <= 2'd1;
              rsp_status <= status_q;
              rsp_rdata  <= '0;
            end else begin
              rsp_code   <= 2'd0;
              rsp_status <= '0;
              rsp_rdata  <= rw_q ? rdata_q : 32'h0;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_initiator
//   Self-checking bench for uart_cmd_initiator. Expected frames and responses
//   come from a byte-queue model of the frame protocol; the CRC reference is
//   computed as polynomial long division of the augmented message.
// ----------------------------------------------------------------------------
module tb_uart_cmd_initiator;

  localparam int TMO = 50;
  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_status;
  logic [1:0]  rsp_code;
  logic        busy;

  uart_cmd_initiator #(
    .TIMEOUT_CYCLES(TMO),
    .SOF_CMD       (8'hA5),
    .SOF_RSP       (8'h5A)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_status(rsp_status),
    .rsp_code  (rsp_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Remainder of (message * x^8) divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc_ref(input byte_q_t msg);
    logic [8:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < msg.size() + 1; i++) begin
      b = (i < msg.size()) ? msg[i] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        r = {r[7:0], b[k]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  // Transmit-side monitor: records every accepted byte and flags any change
  // of tx_data/tx_valid while a byte is stalled.
  byte_q_t    tx_q;
  int         cyc = 0;
  int         hs_cyc = 0;
  int         stab_err = 0;
  bit         pend = 1'b0;
  logic [7:0] pend_data;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && !(tx_valid === 1'b1 && tx_data === pend_data)) stab_err++;
      pend = 1'b0;
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          tx_q.push_back(tx_data);
          hs_cyc = cyc;
        end else begin
          pend      = 1'b1;
          pend_data = tx_data;
        end
      end
    end
  end

  bit tx_rand = 1'b0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_rx(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_txn(input string tag, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [7:0] status, input bit bad_echo, input bit bad_crc,
                         input int noise, input bit no_rsp, input int hold);
    byte_q_t     body, exp_tx, rbody, rframe;
    logic [7:0]  cmd, nb;
    logic [1:0]  e_code;
    logic [7:0]  e_status;
    logic [31:0] e_rdata;
    bit          done;
    int          hold_err, gap, d;

    cmd = rw ? 8'hA0 : 8'h20;
    body.push_back(cmd);
    for (int i = 0; i < 4; i++) body.push_back(addr[8*i +: 8]);
    if (!rw) for (int i = 0; i < 4; i++) body.push_back(wdata[8*i +: 8]);
    exp_tx.push_back(8'hA5);
    foreach (body[i]) exp_tx.push_back(body[i]);
    exp_tx.push_back(crc_ref(body));

    if (no_rsp)                 begin e_code = 2'd3; e_status = 8'h00; e_rdata = 32'h0; end
    else if (bad_crc || bad_echo) begin e_code = 2'd2; e_status = 8'h00; e_rdata = 32'h0; end
    else if (status != 8'h00)   begin e_code = 2'd1; e_status = status; e_rdata = 32'h0; end
    else                        begin e_code = 2'd0; e_status = 8'h00; e_rdata = rw ? rdata : 32'h0; end

    // A stray SOF_RSP while idle must be dropped, not remembered.
    send_rx(8'h5A, 1);

    tx_q.delete();
    stab_err  = 0;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);

    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_q.size() >= exp_tx.size() && tx_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".tx_done"}, done, 1'b1);
    check({tag, ".tx_len"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s.tx_b%0d", tag, i), tx_q[i], exp_tx[i]);
    check({tag, ".tx_stable"}, stab_err, 0);

    if (no_rsp) begin
      done = 1'b0;
      for (int i = 0; i < 4 * TMO; i++) begin
        if (rsp_valid === 1'b1) begin
          done = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      d = cyc - hs_cyc;
      check({tag, ".tmo_seen"}, done, 1'b1);
      check({tag, ".tmo_lat"}, (d >= TMO && d <= TMO + 1), 1'b1);
    end else begin
      for (int i = 0; i < noise; i++) begin
        nb = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        if (nb == 8'h5A) nb = 8'h00;
        send_rx(nb, $urandom_range(0, 2));
      end
      rbody.push_back(status);
      rbody.push_back(bad_echo ? (cmd ^ 8'h80) : cmd);
      if (rw && status == 8'h00) for (int i = 0; i < 4; i++) rbody.push_back(rdata[8*i +: 8]);
      rframe.push_back(8'h5A);
      foreach (rbody[i]) rframe.push_back(rbody[i]);
      rframe.push_back(crc_ref(rbody) ^ (bad_crc ? 8'h10 : 8'h00));
      foreach (rframe[i]) begin
        gap = ($urandom_range(0, 7) == 0) ? TMO - 5 : $urandom_range(0, 2);
        if (i == rframe.size() - 1) gap = 0;
        send_rx(rframe[i], gap);
      end
      check({tag, ".rsp_lat"}, rsp_valid, 1'b1);
    end

    check({tag, ".code"}, rsp_code, e_code);
    check({tag, ".status"}, rsp_status, e_status);
    check({tag, ".rdata"}, rsp_rdata, e_rdata);
    check({tag, ".req_ready_resp"}, req_ready, 1'b0);

    hold_err = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_code !== e_code || rsp_status !== e_status ||
          rsp_rdata !== e_rdata || req_ready !== 1'b0) hold_err++;
    end
    if (hold > 0) check({tag, ".hold"}, hold_err, 0);

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".rsp_done"}, rsp_valid, 1'b0);
    check({tag, ".idle"}, req_ready, 1'b1);
  endtask

  task automatic reset_mid_frame();
    bit done;
    tx_rand   = 1'b0;
    tx_q.delete();
    req_rw    = 1'b0;
    req_addr  = 32'h0BAD_F00D;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_q.size() >= 3) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst.reach_addr", done, 1'b1);
    check("rst.tx_valid_before", tx_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.tx_valid", tx_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst.quiet", tx_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.req_ready", req_ready, 1'b1);
    check("reset.tx_valid", tx_valid, 1'b0);
    check("reset.tx_data", tx_data, 8'h00);
    check("reset.rsp_valid", rsp_valid, 1'b0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.rsp_status", rsp_status, 8'h00);
    check("reset.rsp_code", rsp_code, 2'd0);
    check("reset.busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // tag, rw, addr, wdata, rdata, status, bad_echo, bad_crc, noise, no_rsp, hold
    run_txn("wr_ok",   1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         8'h00, 0, 0, 0, 0, 0);
    run_txn("rd_ok",   1'b1, 32'h0000_1004, 32'h0,         32'h1234_5678, 8'h00, 0, 0, 0, 0, 0);
    tx_rand = 1'b1;
    run_txn("wr_rand", 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         8'h00, 0, 0, 0, 0, 0);
    tx_rand = 1'b0;
    run_txn("rd_bcrc", 1'b1, 32'h0000_2000, 32'h0,         32'hCAFE_F00D, 8'h00, 0, 1, 2, 0, 0);
    run_txn("rd_tmo",  1'b1, 32'h0000_3000, 32'h0,         32'h0,         8'h00, 0, 0, 0, 1, 0);
    run_txn("rd_rerr", 1'b1, 32'h0000_4000, 32'h0,         32'h0,         8'h03, 0, 0, 0, 0, 0);
    run_txn("wr_echo", 1'b0, 32'h0000_5000, 32'h0102_0304, 32'h0,         8'h00, 1, 0, 0, 0, 0);
    run_txn("rd_hold", 1'b1, 32'h0000_6000, 32'h0,         32'h89AB_CDEF, 8'h00, 0, 0, 0, 0, 20);

    reset_mid_frame();
    run_txn("post_rst", 1'b1, 32'hFFFF_FFFC, 32'h0,        32'hA5A5_5A5A, 8'h00, 0, 0, 1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      tx_rand = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", t),
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), ($urandom_range(0, 14) == 0),
              $urandom_range(0, 3));
    end
    tx_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
